// File: rtl/sym_fir_mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : sym_fir_mac_seq_if
// Purpose : Bundles the sample handshake, coefficient bus and result signals
//           of the symmetric FIR engine.
//           master = upstream driver / result consumer, slave = FIR engine.
// Revision: 1.0 - initial release
// ============================================================================
interface sym_fir_mac_seq_if #(
  parameter int TAPS = 8,
  parameter int DW   = 16,
  parameter int CW   = 16
);
  localparam int H  = TAPS / 2;
  localparam int OW = DW + CW + 1 + $clog2(H);

  logic                 start;
  logic signed [DW-1:0] sample_in;
  logic [H*CW-1:0]      coeffs;
  logic                 busy;
  logic signed [OW-1:0] y_out;
  logic                 y_valid;
  logic                 overrun;

  modport master (
    output start, sample_in, coeffs,
    input  busy, y_out, y_valid, overrun
  );

  modport slave (
    input  start, sample_in, coeffs,
    output busy, y_out, y_valid, overrun
  );
endinterface
`default_nettype wire

// File: rtl/sym_fir_mac_seq.sv
`default_nettype none
// ============================================================================
// Module  : sym_fir_mac_seq
// Purpose : Time-multiplexed symmetric FIR. Each accepted start pulse shifts
//           one sample into the delay line, then H=TAPS/2 cycles of
//           pre-add / multiply / accumulate produce one full-precision output
//           presented with a one-cycle valid strobe.
// Revision: 1.0 - initial release
// ============================================================================
module sym_fir_mac_seq #(
  parameter int TAPS = 8,
  parameter int DW   = 16,
  parameter int CW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  sym_fir_mac_seq_if.slave  bus
);

  localparam int H    = TAPS / 2;
  localparam int IDXW = (H > 1) ? $clog2(H) : 1;
  localparam int OW   = DW + CW + 1 + $clog2(H);
  localparam int PW   = DW + CW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic signed [DW-1:0] x_q [TAPS];
  logic signed [DW-1:0] x_d [TAPS];
  logic signed [OW-1:0] acc_q, acc_d;
  logic signed [OW-1:0] y_q, y_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 y_valid_q, y_valid_d;
  logic                 overrun_q, overrun_d;

  logic signed [CW-1:0] coef [H];
  logic signed [DW-1:0] tap_a;
  logic signed [DW-1:0] tap_b;
  logic signed [CW-1:0] tap_c;
  logic signed [DW:0]   pre_sum;
  logic signed [PW-1:0] product;
  logic signed [OW-1:0] term;
  logic signed [OW-1:0] acc_sum;
  logic                 last_iter;

  // Unpack the flat coefficient bus into a signed array.
  generate
    for (genvar k = 0; k < H; k++) begin : g_coef
      assign coef[k] = bus.coeffs[k*CW +: CW];
    end
  endgenerate

  // Select the mirrored tap pair and its shared coefficient for this iteration.
  always_comb begin
    tap_a = x_q[0];
    tap_b = x_q[TAPS-1];
    tap_c = coef[0];
    for (int k = 0; k < H; k++) begin
      if (idx_q == IDXW'(k)) begin
        tap_a = x_q[k];
        tap_b = x_q[TAPS-1-k];
        tap_c = coef[k];
      end
    end
  end

  // Pre-add, multiply and accumulate; every stage is sign-extended so no bits are lost.
  always_comb begin
    pre_sum   = (DW+1)'(tap_a) + (DW+1)'(tap_b);
    product   = PW'(pre_sum) * PW'(tap_c);
    term      = OW'(product);
    acc_sum   = acc_q + term;
    last_iter = (idx_q == IDXW'(H-1));
  end

  // Next-state, datapath update and output strobes.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = TAPS-1; i > 0; i--) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0]  = bus.sample_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        // A start arriving mid-computation is dropped and flagged.
        overrun_d = bus.start;
        acc_d     = acc_sum;
        idx_d     = idx_q + IDXW'(1);
        if (last_iter) begin
          y_d       = acc_sum;
          y_valid_d = 1'b1;
          idx_d     = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
      acc_q     <= '0;
      idx_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.busy    = (state_q == MAC);
  assign bus.y_out   = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sym_fir_mac_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_sym_fir_mac_seq
// Purpose : Self-checking bench for sym_fir_mac_seq: vector table, hand
//           sequences for latency/overrun/reset, and randomized traffic
//           against a direct-form convolution model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sym_fir_mac_seq;

  localparam int TAPS = 8;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int H    = TAPS / 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sym_fir_mac_seq_if #(.TAPS(TAPS), .DW(DW), .CW(CW)) bus ();

  sym_fir_mac_seq #(.TAPS(TAPS), .DW(DW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [H*CW-1:0]      coeffs;
    logic signed [DW-1:0] sample;
    longint               y_exp;
  } vec_t;

  vec_t   tbl [25];
  int     vectors    = 0;
  int     miscompares = 0;

  // Reference model state: interval counter and spec-level timing bookkeeping.
  int     cur        = 0;
  int     model_free = 0;
  int     due        = -1;
  int     ovr_due    = -1;
  int     dropped    = 0;
  int     ovr_seen   = 0;
  longint pend_y     = 0;
  longint y_exp      = 0;
  longint mline [TAPS];

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cur);
    end
  endtask

  function automatic logic [H*CW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  // Direct-form convolution: tap i uses coefficient min(i, TAPS-1-i).
  function automatic longint model_y();
    longint s;
    int     k;
    s = 0;
    for (int i = 0; i < TAPS; i++) begin
      k = (i < H) ? i : TAPS - 1 - i;
      s += mline[i] * longint'($signed(bus.coeffs[k*CW +: CW]));
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic check_cycle();
    if (cur == due) y_exp = pend_y;
    chk("busy",    longint'(bus.busy),    longint'(cur < model_free));
    chk("y_valid", longint'(bus.y_valid), longint'(cur == due));
    chk("overrun", longint'(bus.overrun), longint'(cur == ovr_due));
    chk("y_out",   longint'(bus.y_out),   y_exp);
    if (bus.overrun) ovr_seen++;
  endtask

  task automatic step(input bit st, input logic signed [DW-1:0] s);
    bus.start     = st;
    bus.sample_in = s;
    if (st) begin
      if (cur >= model_free) begin
        for (int i = TAPS-1; i > 0; i--) mline[i] = mline[i-1];
        mline[0]   = longint'(s);
        pend_y     = model_y();
        due        = cur + H + 1;
        model_free = cur + H + 1;
      end else begin
        ovr_due = cur + 1;
        dropped++;
      end
    end
    tick();
    bus.start = 1'b0;
    check_cycle();
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < TAPS; i++) mline[i] = 0;
    model_free = cur;
    due        = -1;
    ovr_due    = -1;
    y_exp      = 0;
    pend_y     = 0;
    check_cycle();
    rst = 1'b1;
  endtask

  task automatic apply_row(input int r);
    bus.coeffs = tbl[r].coeffs;
    step(1'b1, tbl[r].sample);
    repeat (H) step(1'b0, '0);
    chk("tbl_y_valid", longint'(bus.y_valid), 1);
    chk("tbl_y_out",   longint'(bus.y_out),   tbl[r].y_exp);
  endtask

  initial begin
    logic [H*CW-1:0] c1234;
    logic [H*CW-1:0] cneg;
    int              impulse [8];
    int              ngap;

    c1234   = pack4(1, 2, 3, 4);
    cneg    = pack4(-32768, -32768, -32768, -32768);
    impulse = '{1, 2, 3, 4, 4, 3, 2, 1};

    // Impulse response, then the ninth (zero) sample flushes it out.
    for (int r = 0; r < 8; r++) begin
      tbl[r].coeffs = c1234;
      tbl[r].sample = (r == 0) ? 16'sd1 : 16'sd0;
      tbl[r].y_exp  = impulse[r];
    end
    tbl[8].coeffs = c1234;
    tbl[8].sample = 16'sd0;
    tbl[8].y_exp  = 0;
    // Line fills with -32768; every tap weight is -32768, so y = k * 2^30.
    for (int k = 1; k <= 8; k++) begin
      tbl[8+k].coeffs = cneg;
      tbl[8+k].sample = -16'sd32768;
      tbl[8+k].y_exp  = longint'(k) * (longint'(1) << 30);
    end
    // Line refills with +32767: y = -32768 * (j*32767 - (8-j)*32768).
    for (int j = 1; j <= 8; j++) begin
      tbl[16+j].coeffs = cneg;
      tbl[16+j].sample = 16'sd32767;
      tbl[16+j].y_exp  = -32768 * (longint'(j) * 32767 - longint'(8 - j) * 32768);
    end

    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.sample_in = '0;
    bus.coeffs    = '0;
    for (int i = 0; i < TAPS; i++) mline[i] = 0;
    do_reset();
    do_reset();

    // Table vectors: impulse and arithmetic extremes.
    for (int r = 0; r < 25; r++) apply_row(r);
    repeat (2) step(1'b0, '0);

    // Latency and back-to-back throughput.
    bus.coeffs = c1234;
    step(1'b1, 16'sd3);
    chk("lat_busy_s1", longint'(bus.busy), 1);
    repeat (3) begin
      step(1'b0, '0);
      chk("lat_busy", longint'(bus.busy), 1);
    end
    step(1'b0, '0);
    chk("lat_yv_s5",   longint'(bus.y_valid), 1);
    chk("lat_busy_s5", longint'(bus.busy),    0);
    step(1'b1, 16'sd0);
    repeat (H) step(1'b0, '0);
    chk("lat_yv_s10", longint'(bus.y_valid), 1);
    repeat (2) step(1'b0, '0);

    // Overrun: second start two cycles later is dropped.
    step(1'b1, 16'sd5);
    step(1'b0, '0);
    step(1'b1, 16'sd7);
    chk("ovr_pulse", longint'(bus.overrun), 1);
    step(1'b0, '0);
    chk("ovr_clear", longint'(bus.overrun), 0);
    step(1'b0, '0);
    chk("ovr_yv", longint'(bus.y_valid), 1);
    repeat (3) step(1'b0, '0);

    // Reset in the middle of a computation.
    bus.coeffs = c1234;
    step(1'b1, 16'sd9);
    step(1'b0, '0);
    do_reset();
    chk("rst_busy",  longint'(bus.busy),  0);
    chk("rst_y_out", longint'(bus.y_out), 0);
    repeat (6) step(1'b0, '0);
    for (int r = 0; r < 5; r++) apply_row(r);
    repeat (2) step(1'b0, '0);

    // Randomized traffic with random start spacing.
    dropped  = 0;
    ovr_seen = 0;
    for (int n = 0; n < 200; n++) begin
      if (n % 50 == 0) begin
        while (cur < model_free) step(1'b0, '0);
        bus.coeffs = {$urandom, $urandom};
      end
      ngap = $urandom_range(0, 6);
      repeat (ngap) step(1'b0, '0);
      step(1'b1, 16'($urandom));
    end
    repeat (H + 2) step(1'b0, '0);
    chk("ovr_count", longint'(ovr_seen), longint'(dropped));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
